keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
- Sequences the key-code source for the keypad subsystem: scans a physical 4x4 active-low matrix keypad, or steps the autokey code generator when auto mode is selected.
- Debounces physical presses and encodes row/column to the system key code.
- Emits one key_valid pulse per accepted key, which downstream display/entry logic consumes.

Parameters:
- CLK_DIV, 50000, clk cycles per scan tick (minimum 2).
- DEB_CNT, 4, consecutive identical scan ticks required to accept a press or a release (minimum 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- auto_en  in  1  1 = take codes from the autokey generator; 0 = physical keypad
- auto_code  in  4  registered code output of the autokey generator
- auto_step  out  1  one-clk clock-enable pulse that advances the autokey generator
- row  out  4  row drive, active-low, one row low at a time
- col  in  4  column sense, active-low, asynchronous, pulled up
- key_code  out  4  last accepted code
- key_valid  out  1  one-clk pulse when key_code updates
- key_held  out  1  physical key currently accepted and not yet released

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset values:
  - row=4'b1110, row index r=0
  - key_code=4'hF, key_valid=0, key_held=0, auto_step=0
  - divider=0, debounce counters=0, state=SCAN
- col passes through a 2-flop synchronizer before use.
- Tick divider:
  - Counts 0..CLK_DIV-1, then wraps.
  - tick is a one-clk pulse when count==CLK_DIV-1.
  - Free-running in all states.
- Key index idx = 4*r + c, where c is the lowest-numbered low column (col0 has priority).
- Keymap, idx 0..15 -> code: F,E,D,C,B,3,6,9,A,2,5,8,0,1,4,7.
- FSM states:
  - SCAN:
    - On tick with all synced col high: r <= r+1 (wraps 3->0) and row follows.
    - On tick with any col low: latch idx, deb=1, freeze row, go to DEBOUNCE.
    - If auto_en=1 at a tick: go to AUTO, row=4'hF. This check has priority over key detection on the same tick.
  - DEBOUNCE:
    - On tick with the same idx: deb++.
    - When deb reaches DEB_CNT: key_code <= keymap(idx), key_valid pulses on the next clk, go to HELD.
    - On tick with a different idx or no key: deb=0, resume SCAN at the same r. No pulse.
    - With DEB_CNT=1, acceptance happens on the detecting tick.
  - HELD:
    - key_held=1.
    - Each tick with all col high increments rel; any low col clears rel.
    - When rel reaches DEB_CNT: key_held=0, rel=0, go to SCAN at r+1.
    - auto_en is ignored until release completes.
  - AUTO:
    - Each tick: auto_step=1 for one clk.
    - The generator updates auto_code at the end of that clk.
    - The next clk samples auto_code into key_code; key_valid pulses the clk after that. Latency from auto_step to key_valid is 2 clks.
    - On a tick with auto_en=0: go to SCAN, r=0, row=4'b1110, no step.
- key_valid and auto_step are never high for more than one consecutive clk.
- Exactly one key_valid per accepted physical press, regardless of hold length.
- Multiple keys in the frozen row: the lowest col wins. A change of the winning col during DEBOUNCE restarts the scan; during HELD it is ignored until all keys are released.
- Reset mid-operation: immediate return to reset values, no pending pulse emitted.

Decomposition:
- Package keypad_pkg contains:
  - state encoding (SCAN, DEBOUNCE, HELD, AUTO)
  - KEYMAP constant/function (idx -> code)
  - KEY_RESET_CODE=4'hF
  - row one-hot-low helper
- Sub-module scan_tick_div(CLK_DIV): clk, rst_n -> tick.
- Synchronizer and FSM stay in keypad_scan_ctrl.

Test Plan (CLK_DIV=4, DEB_CNT=3, behavioural keypad model):
- Reset release, no key -> row cycles E,D,B,7 every 4 clks; key_code=F, key_valid=0, key_held=0, auto_step=0.
- Press row1/col2 (idx 6) for 10 ticks -> one key_valid pulse, key_code=6, key_held=1; release -> key_held=0 after 3 idle ticks, no second pulse.
- Press row0/col0 for 2 ticks then release (bounce) -> no key_valid, key_code stays F, scanning resumes.
- auto_en=1 with the autokey model -> auto_step every 4 clks; key_code sequence F,E,D,C,B,3,... with key_valid 2 clks after each auto_step. Drop auto_en -> row=E, stepping stops.
- Hold row3/col3 (idx 15 -> 7), then raise auto_en -> no auto_step until release is debounced, then AUTO entered at the next tick.
- Assert rst_n low mid-DEBOUNCE of row2/col1 -> all outputs at reset values immediately; no key_valid after rst_n deasserts unless re-debounced.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad key-code source: state encoding,
// row/column helpers and the matrix-position to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    AUTO     = 2'd3
  } state_t;

  localparam logic [3:0] KEY_RESET_CODE = 4'hF;

  function automatic logic [3:0] keymap(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'hF;
      4'd1:    code = 4'hE;
      4'd2:    code = 4'hD;
      4'd3:    code = 4'hC;
      4'd4:    code = 4'hB;
      4'd5:    code = 4'h3;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'h9;
      4'd8:    code = 4'hA;
      4'd9:    code = 4'h2;
      4'd10:   code = 4'h5;
      4'd11:   code = 4'h8;
      4'd12:   code = 4'h0;
      4'd13:   code = 4'h1;
      4'd14:   code = 4'h4;
      default: code = 4'h7;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Lowest-numbered low column wins when several keys share a row.
  function automatic logic [1:0] low_col(input logic [3:0] col);
    logic [1:0] c;
    if (!col[0])      c = 2'd0;
    else if (!col[1]) c = 2'd1;
    else if (!col[2]) c = 2'd2;
    else              c = 2'd3;
    return c;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad matrix, autokey generator and key-output signals of the scan controller.
interface keypad_scan_ctrl_if;
  logic       auto_en;
  logic [3:0] auto_code;
  logic       auto_step;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  auto_en, auto_code, col,
    output auto_step, row, key_code, key_valid, key_held
  );

  modport slave (
    output auto_en, auto_code, col,
    input  auto_step, row, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl_tick_div.sv
// Free-running scan tick divider: one-clk tick every CLK_DIV clocks.
module scan_tick_div #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad key-code source: scans and debounces a 4x4 active-low matrix, or
// steps the external autokey generator, and emits one key_valid per key.
//
// state    | meaning
// SCAN     | walking rows, looking for a low column on each tick
// DEBOUNCE | row frozen, counting ticks with the same key index
// HELD     | key accepted, waiting for DEB_CNT idle ticks
// AUTO     | rows idle, stepping the autokey generator once per tick
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DEB_CNT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  keypad_scan_ctrl_if.master  kp
);

  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

  logic          tick;
  logic [3:0]    col_s1, col_s2;
  state_t        state, state_nxt;
  logic [1:0]    r, r_nxt;
  logic [3:0]    idx_q, idx_nxt;
  logic [DW-1:0] deb, deb_nxt;
  logic [DW-1:0] rel, rel_nxt;
  logic [3:0]    code_q, code_nxt;
  logic          valid_q, valid_nxt;
  logic          held_q, held_nxt;
  logic          step_q, step_nxt;
  logic          samp_q;
  logic          key_any;
  logic [3:0]    cur_idx;

  scan_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= kp.col;
      col_s2 <= col_s1;
    end
  end

  assign key_any = (col_s2 != 4'hF);
  assign cur_idx = {r, low_col(col_s2)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      r       <= 2'd0;
      idx_q   <= 4'd0;
      deb     <= '0;
      rel     <= '0;
      code_q  <= KEY_RESET_CODE;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      step_q  <= 1'b0;
      samp_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      r       <= r_nxt;
      idx_q   <= idx_nxt;
      deb     <= deb_nxt;
      rel     <= rel_nxt;
      code_q  <= code_nxt;
      valid_q <= valid_nxt;
      held_q  <= held_nxt;
      step_q  <= step_nxt;
      samp_q  <= step_q;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    idx_nxt   = idx_q;
    deb_nxt   = deb;
    rel_nxt   = rel;
    code_nxt  = code_q;
    valid_nxt = 1'b0;
    held_nxt  = held_q;
    step_nxt  = 1'b0;

    // Generator output is valid one clk after the step pulse.
    if (samp_q) begin
      code_nxt  = kp.auto_code;
      valid_nxt = 1'b1;
    end

    case (state)
      SCAN: begin
        if (tick) begin
          if (kp.auto_en) begin
            state_nxt = AUTO;
          end else if (key_any) begin
            idx_nxt = cur_idx;
            if (DEB_CNT == 1) begin
              code_nxt  = keymap(cur_idx);
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              deb_nxt   = '0;
              state_nxt = HELD;
            end else begin
              deb_nxt   = DW'(1);
              state_nxt = DEBOUNCE;
            end
          end else begin
            r_nxt = r + 2'd1;
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (key_any && (cur_idx == idx_q)) begin
            if (deb == DEB_LAST) begin
              code_nxt  = keymap(idx_q);
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              deb_nxt   = '0;
              state_nxt = HELD;
            end else begin
              deb_nxt = deb + DW'(1);
            end
          end else begin
            deb_nxt   = '0;
            state_nxt = SCAN;
          end
        end
      end

      HELD: begin
        if (tick) begin
          if (!key_any) begin
            if (rel == DEB_LAST) begin
              held_nxt  = 1'b0;
              rel_nxt   = '0;
              r_nxt     = r + 2'd1;
              state_nxt = SCAN;
            end else begin
              rel_nxt = rel + DW'(1);
            end
          end else begin
            rel_nxt = '0;
          end
        end
      end

      AUTO: begin
        if (tick) begin
          if (!kp.auto_en) begin
            r_nxt     = 2'd0;
            state_nxt = SCAN;
          end else begin
            step_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = SCAN;
    endcase
  end

  assign kp.row       = (state == AUTO) ? 4'hF : row_drive(r);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
  assign kp.auto_step = step_q;

endmodule
